// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_pkg
// Brief    : Opcodes, command/error encodings and FSM states for uart_cmd_parser
// Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    localparam logic [7:0] c_OP_WR      = 8'hAA;
    localparam logic [7:0] c_OP_RD      = 8'hBB;
    localparam logic [7:0] c_OP_ALU     = 8'hCC;
    localparam logic [7:0] c_OP_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        CMD_WR      = 2'd0,
        CMD_RD      = 2'd1,
        CMD_ALU     = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        ERR_BAD_OPCODE = 2'd0,
        ERR_LINE       = 2'd1,
        ERR_TIMEOUT    = 2'd2,
        ERR_OVERRUN    = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    typedef struct packed {
        logic      known;
        cmd_type_e kind;
        logic [1:0] nargs;
    } op_info_t;

    function automatic op_info_t decode_opcode(input logic [7:0] op);
        op_info_t info;
        info = '{known: 1'b0, kind: CMD_WR, nargs: 2'd0};
        case (op)
            c_OP_WR:      info = '{known: 1'b1, kind: CMD_WR,      nargs: 2'd2};
            c_OP_RD:      info = '{known: 1'b1, kind: CMD_RD,      nargs: 2'd1};
            c_OP_ALU:     info = '{known: 1'b1, kind: CMD_ALU,     nargs: 2'd3};
            c_OP_ALU_NOP: info = '{known: 1'b1, kind: CMD_ALU_NOP, nargs: 2'd1};
            default:      info = '{known: 1'b0, kind: CMD_WR,      nargs: 2'd0};
        endcase
        return info;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_timer
// Brief    : Inter-byte idle timer; exists only when UART_CMD_TIMEOUT_EN is set
// Revision : 1.0 - initial release
// ============================================================================
`ifdef UART_CMD_TIMEOUT_EN
module uart_cmd_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [15:0] c_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 16'd0;
        end else if (clear) begin
            r_count <= 16'd0;
        end else if (run) begin
            r_count <= r_count + 16'd1;
        end
    end

    // r_count holds the number of idle cycles already elapsed before this one
    assign expired = run & (r_count == c_LAST);

endmodule
`endif
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser
// Brief    : Frames UART bytes into commands; UART_CMD_TIMEOUT_EN adds a timer
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_par_err,
    input  logic       rx_frm_err,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_type,
    output logic [7:0] cmd_arg0,
    output logic [7:0] cmd_arg1,
    output logic [7:0] cmd_arg2,
    output logic       err_pulse,
    output logic [1:0] err_code
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("uart_cmd_parser: TIMEOUT_CYCLES out of range 2..65535");
    end

    state_e     r_state;
    logic [1:0] r_nargs;
    logic [1:0] r_idx;
    op_info_t   w_op;
    logic       w_line_err;
    logic       w_xfer;
    logic       w_idle_byte;
    logic       w_expired;

    assign w_line_err  = rx_par_err | rx_frm_err;
    assign w_xfer      = cmd_valid & cmd_ready;
    assign w_op        = decode_opcode(rx_data);
    // The handshake cycle already frees the slot, so its byte starts a new frame
    assign w_idle_byte = rx_valid & ((r_state == ST_IDLE) | ((r_state == ST_HOLD) & w_xfer));

`ifdef UART_CMD_TIMEOUT_EN
    uart_cmd_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (rx_valid | (r_state != ST_COLLECT)),
        .run     (r_state == ST_COLLECT),
        .expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_nargs   <= 2'd0;
            r_idx     <= 2'd0;
            cmd_valid <= 1'b0;
            cmd_type  <= CMD_WR;
            cmd_arg0  <= 8'h00;
            cmd_arg1  <= 8'h00;
            cmd_arg2  <= 8'h00;
            err_pulse <= 1'b0;
            err_code  <= ERR_BAD_OPCODE;
        end else begin
            err_pulse <= 1'b0;

            case (r_state)
                ST_COLLECT: begin
                    if (rx_valid) begin
                        if (w_line_err) begin
                            r_state   <= ST_IDLE;
                            err_pulse <= 1'b1;
                            err_code  <= ERR_LINE;
                        end else begin
                            case (r_idx)
                                2'd0:    cmd_arg0 <= rx_data;
                                2'd1:    cmd_arg1 <= rx_data;
                                default: cmd_arg2 <= rx_data;
                            endcase
                            if (r_idx == r_nargs - 2'd1) begin
                                r_state   <= ST_HOLD;
                                cmd_valid <= 1'b1;
                            end else begin
                                r_idx <= r_idx + 2'd1;
                            end
                        end
                    end else if (w_expired) begin
                        r_state   <= ST_IDLE;
                        err_pulse <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                    end
                end
                ST_HOLD: begin
                    if (w_xfer) begin
                        r_state   <= ST_IDLE;
                        cmd_valid <= 1'b0;
                    end else if (rx_valid) begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_OVERRUN;
                    end
                end
                default: ;
            endcase

            // Placed last so it overrides the HOLD exit when a byte rides the handshake
            if (w_idle_byte) begin
                if (w_line_err) begin
                    r_state   <= ST_IDLE;
                    err_pulse <= 1'b1;
                    err_code  <= ERR_LINE;
                end else if (w_op.known) begin
                    r_state  <= ST_COLLECT;
                    r_nargs  <= w_op.nargs;
                    r_idx    <= 2'd0;
                    cmd_type <= w_op.kind;
                    cmd_arg0 <= 8'h00;
                    cmd_arg1 <= 8'h00;
                    cmd_arg2 <= 8'h00;
                end else begin
                    err_pulse <= 1'b1;
                    err_code  <= ERR_BAD_OPCODE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_parser
// Brief    : Directed and random checks of uart_cmd_parser (UART_CMD_TIMEOUT_EN aware)
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_par_err = 1'b0;
    logic       rx_frm_err = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_type;
    logic [7:0] cmd_arg0, cmd_arg1, cmd_arg2;
    logic       err_pulse;
    logic [1:0] err_code;

    int n_cmp = 0;
    int n_bad = 0;

    logic [25:0] obs_cmd[$];
    logic [25:0] exp_cmd[$];
    logic [1:0]  obs_err[$];
    logic [1:0]  exp_err[$];
    logic [7:0]  model_q[$];
    logic [7:0]  ops[4];

    uart_cmd_parser #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_par_err (rx_par_err),
        .rx_frm_err (rx_frm_err),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_type   (cmd_type),
        .cmd_arg0   (cmd_arg0),
        .cmd_arg1   (cmd_arg1),
        .cmd_arg2   (cmd_arg2),
        .err_pulse  (err_pulse),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) obs_cmd.push_back({cmd_type, cmd_arg0, cmd_arg1, cmd_arg2});
        if (err_pulse) obs_err.push_back(err_code);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cmd(input string tag, input logic [1:0] t,
                             input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
        check(tag, 32'({cmd_valid, cmd_type, cmd_arg0, cmd_arg1, cmd_arg2}),
              32'({1'b1, t, a0, a1, a2}));
    endtask

    task automatic check_err(input string tag, input logic pulse, input logic [1:0] code);
        check(tag, 32'({err_pulse, err_code}), 32'({pulse, code}));
    endtask

    task automatic send_byte(input logic [7:0] d, input logic pe, input logic fe);
        rx_data    = d;
        rx_valid   = 1'b1;
        rx_par_err = pe;
        rx_frm_err = fe;
        tick();
        rx_valid   = 1'b0;
        rx_par_err = 1'b0;
        rx_frm_err = 1'b0;
    endtask

    function automatic int nargs_of(input logic [7:0] op);
        case (op)
            8'hAA:   return 2;
            8'hBB:   return 1;
            8'hCC:   return 3;
            8'hDD:   return 1;
            default: return -1;
        endcase
    endfunction

    function automatic logic [1:0] type_of(input logic [7:0] op);
        case (op)
            8'hAA:   return 2'd0;
            8'hBB:   return 2'd1;
            8'hCC:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Frame-level reference: a byte queue per frame, a command when it is complete
    task automatic model_byte(input logic [7:0] d, input logic lerr);
        logic [7:0] a[3];
        if (lerr) begin
            exp_err.push_back(2'd1);
            model_q.delete();
        end else if (model_q.size() == 0) begin
            if (nargs_of(d) < 0) exp_err.push_back(2'd0);
            else model_q.push_back(d);
        end else begin
            model_q.push_back(d);
            if (model_q.size() == nargs_of(model_q[0]) + 1) begin
                a = '{8'h00, 8'h00, 8'h00};
                for (int i = 1; i < model_q.size(); i++) a[i-1] = model_q[i];
                exp_cmd.push_back({type_of(model_q[0]), a[0], a[1], a[2]});
                model_q.delete();
            end
        end
    endtask

    task automatic send_rand(input logic [7:0] d, input logic lerr);
        logic pe;
        repeat ($urandom_range(0, 2)) tick();
        model_byte(d, lerr);
        pe = lerr & 1'($urandom_range(0, 1));
        send_byte(d, pe, lerr & ~pe);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] op;
        int         kind;
        int         k;

        ops = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

        // Reset state
        tick();
        tick();
        check("reset_outputs", 32'({cmd_valid, cmd_type, cmd_arg0, cmd_arg1, cmd_arg2, err_pulse, err_code}), 32'd0);
        rst_n = 1'b1;
        tick();

        // S1: WR with ready high
        obs_cmd.delete(); obs_err.delete();
        cmd_ready = 1'b1;
        send_byte(8'hAA, 0, 0);
        send_byte(8'h05, 0, 0);
        check("s1_not_early", 32'(cmd_valid), 32'd0);
        send_byte(8'h3C, 0, 0);
        check_cmd("s1_cmd", 2'd0, 8'h05, 8'h3C, 8'h00);
        tick();
        check("s1_valid_drop", 32'(cmd_valid), 32'd0);
        check("s1_xfer_count", obs_cmd.size(), 32'd1);
        check("s1_no_err", obs_err.size(), 32'd0);

        // S2: ALU held with ready low, overrun during hold
        obs_cmd.delete(); obs_err.delete();
        cmd_ready = 1'b0;
        send_byte(8'hCC, 0, 0);
        send_byte(8'h10, 0, 0);
        send_byte(8'h20, 0, 0);
        send_byte(8'h01, 0, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                rx_data  = 8'h7F;
                rx_valid = 1'b1;
            end
            tick();
            rx_valid = 1'b0;
            check_cmd("s2_hold", 2'd2, 8'h10, 8'h20, 8'h01);
            if (i == 4) check_err("s2_overrun", 1'b1, 2'd3);
            if (i == 5) check_err("s2_code_held", 1'b0, 2'd3);
        end
        cmd_ready = 1'b1;
        tick();
        check("s2_valid_drop", 32'(cmd_valid), 32'd0);
        check("s2_xfer_count", obs_cmd.size(), 32'd1);
        if (obs_cmd.size() > 0) check("s2_xfer_value", 32'(obs_cmd[0]), 32'({2'd2, 8'h10, 8'h20, 8'h01}));

        // S3: bad opcode then RD
        send_byte(8'h55, 0, 0);
        check_err("s3_bad_opcode", 1'b1, 2'd0);
        check("s3_no_valid", 32'(cmd_valid), 32'd0);
        send_byte(8'hBB, 0, 0);
        send_byte(8'h09, 0, 0);
        check_cmd("s3_rd", 2'd1, 8'h09, 8'h00, 8'h00);

        // S4: parity error aborts WR, then ALU_NOP
        tick();
        send_byte(8'hAA, 0, 0);
        send_byte(8'h05, 0, 0);
        send_byte(8'h11, 1, 0);
        check_err("s4_line_err", 1'b1, 2'd1);
        check("s4_no_valid", 32'(cmd_valid), 32'd0);
        send_byte(8'hDD, 0, 0);
        send_byte(8'h02, 0, 0);
        check_cmd("s4_nop", 2'd3, 8'h02, 8'h00, 8'h00);
        tick();

`ifdef UART_CMD_TIMEOUT_EN
        // S5: timeout after 16 idle cycles; byte in the expiry cycle wins
        send_byte(8'hAA, 0, 0);
        repeat (15) tick();
        check("s5_before_expiry", 32'(err_pulse), 32'd0);
        tick();
        check_err("s5_timeout", 1'b1, 2'd2);
        send_byte(8'hBB, 0, 0);
        send_byte(8'h07, 0, 0);
        check_cmd("s5_idle_after_timeout", 2'd1, 8'h07, 8'h00, 8'h00);
        tick();
        obs_err.delete();
        send_byte(8'hAA, 0, 0);
        repeat (15) tick();
        send_byte(8'h42, 0, 0);
        check("s5_expiry_byte_no_err", 32'(err_pulse), 32'd0);
        send_byte(8'h43, 0, 0);
        check_cmd("s5_expiry_cmd", 2'd0, 8'h42, 8'h43, 8'h00);
        tick();
        check("s5_err_count", obs_err.size(), 32'd0);
`else
        // S5: without the timer a long gap is harmless
        obs_err.delete();
        send_byte(8'hAA, 0, 0);
        repeat (40) tick();
        send_byte(8'h01, 0, 0);
        send_byte(8'h02, 0, 0);
        check_cmd("s5_no_timeout_cmd", 2'd0, 8'h01, 8'h02, 8'h00);
        tick();
        check("s5_err_count", obs_err.size(), 32'd0);
`endif

        // S6: reset mid-frame
        obs_err.delete();
        send_byte(8'hCC, 0, 0);
        send_byte(8'h01, 0, 0);
        rst_n = 1'b0;
        #1;
        check("s6_async_reset", 32'({cmd_valid, cmd_type, cmd_arg0, cmd_arg1, cmd_arg2, err_pulse, err_code}), 32'd0);
        tick();
        tick();
        check("s6_reset_held", 32'({cmd_valid, cmd_type, cmd_arg0, cmd_arg1, cmd_arg2, err_pulse, err_code}), 32'd0);
        rst_n = 1'b1;
        send_byte(8'hBB, 0, 0);
        send_byte(8'h04, 0, 0);
        check_cmd("s6_after_reset", 2'd1, 8'h04, 8'h00, 8'h00);
        tick();
        check("s6_no_err", obs_err.size(), 32'd0);

        // Random byte streams against the frame-level model, ready held high
        repeat (3) tick();
        obs_cmd.delete(); obs_err.delete();
        exp_cmd.delete(); exp_err.delete(); model_q.delete();
        for (int it = 0; it < 60; it++) begin
            kind = int'($urandom_range(0, 9));
            op = ops[$urandom_range(0, 3)];
            if (kind <= 6) begin
                send_rand(op, 1'b0);
                for (int j = 0; j < nargs_of(op); j++) send_rand(8'($urandom_range(0, 255)), 1'b0);
            end else if (kind == 7) begin
                do d = 8'($urandom_range(0, 255)); while (nargs_of(d) >= 0);
                send_rand(d, 1'b0);
            end else if (kind == 8) begin
                send_rand(op, 1'b0);
                k = int'($urandom_range(0, nargs_of(op) - 1));
                for (int j = 0; j < k; j++) send_rand(8'($urandom_range(0, 255)), 1'b0);
                send_rand(8'($urandom_range(0, 255)), 1'b1);
            end else begin
                send_rand(8'($urandom_range(0, 255)), 1'b1);
            end
        end
        repeat (4) tick();
        check("rand_cmd_count", obs_cmd.size(), exp_cmd.size());
        for (int i = 0; i < obs_cmd.size() && i < exp_cmd.size(); i++)
            check("rand_cmd", 32'(obs_cmd[i]), 32'(exp_cmd[i]));
        check("rand_err_count", obs_err.size(), exp_err.size());
        for (int i = 0; i < obs_err.size() && i < exp_err.size(); i++)
            check("rand_err", 32'(obs_err[i]), 32'(exp_err[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 4096, maximum idle cycles allowed between bytes inside one frame (range 2..65535).
REQ-002 CLK  input  1  single clock, the UART RX clock domain.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 RX_DATA  input  8  received byte from UART_RX.
REQ-005 RX_VALID  input  1  one-cycle strobe marking RX_DATA valid.
REQ-006 RX_PAR_ERR  input  1  parity error for the byte strobed by RX_VALID.
REQ-007 RX_FRM_ERR  input  1  framing error for the byte strobed by RX_VALID.
REQ-008 CMD_READY  input  1  downstream accepts the command.
REQ-009 CMD_VALID  output  1  decoded command is available.
REQ-010 CMD_TYPE  output  2  command type: 0 WR, 1 RD, 2 ALU, 3 ALU_NOP.
REQ-011 CMD_ARG0 / CMD_ARG1 / CMD_ARG2  output  8 each  arguments in received order.
REQ-012 ERR_PULSE  output  1  one-cycle error strobe.
REQ-013 ERR_CODE  output  2  error type: 0 bad opcode, 1 line error, 2 timeout, 3 overrun.

Function
REQ-014 Opcode table, shall be decoded exactly as listed:
- 0xAA: WR, 2 arguments (addr, data).
- 0xBB: RD, 1 argument (addr).
- 0xCC: ALU, 3 arguments (A, B, fun).
- 0xDD: ALU_NOP, 1 argument (fun).
REQ-015 FSM states IDLE, COLLECT, HOLD.
- IDLE: valid opcode byte goes to COLLECT and loads the argument count.
- COLLECT: each byte fills the next ARG register; the last byte goes to HOLD.
- HOLD: leaves to IDLE on handshake.
REQ-016 CMD_VALID shall rise the cycle after the RX_VALID of the final argument byte.
REQ-017 CMD_VALID and all CMD_* outputs shall stay stable while CMD_VALID=1 and CMD_READY=0.
REQ-018 Transfer occurs when CMD_VALID and CMD_READY are both high; CMD_VALID shall be low the next cycle.
REQ-019 RX_VALID in the transfer cycle shall be processed as an IDLE byte.
REQ-020 Unused ARG registers shall read 0x00.
REQ-021 Unknown opcode in IDLE: byte discarded, ERR_PULSE with code 0, stay IDLE.
REQ-022 Byte with RX_PAR_ERR or RX_FRM_ERR, in any state except HOLD: byte discarded, partial frame aborted, ERR_PULSE with code 1, go to IDLE.
REQ-023 Any byte arriving in HOLD (outside the transfer cycle): byte dropped, ERR_PULSE with code 3, pending command unchanged.
REQ-024 ERR_CODE shall hold its last value until the next ERR_PULSE.
REQ-025 When multiple error conditions occur in one cycle, the priority is line error, then overrun, then bad opcode.

Reset
REQ-026 Asserting RST low shall immediately set: FSM=IDLE, CMD_VALID=0, CMD_TYPE=0, ARG0..2=0x00, ERR_PULSE=0, ERR_CODE=0, timer=0.
REQ-027 Reset mid-frame or in HOLD shall discard the frame without any ERR_PULSE.
REQ-028 The first byte after reset release shall be treated as an opcode.

Configuration
REQ-029 Macro UART_CMD_TIMEOUT_EN, when defined, shall enable the inter-byte timer:
- The timer clears on every accepted byte and counts only in COLLECT.
- When it reaches TIMEOUT_CYCLES without a byte: frame aborted, ERR_PULSE with code 2, go to IDLE.
- A byte arriving in the expiry cycle wins: it is accepted, the timer clears, and no timeout is reported.
REQ-030 Without UART_CMD_TIMEOUT_EN, no timer logic shall exist, COLLECT shall wait indefinitely, and ERR_CODE 2 shall never occur.

Structure
REQ-031 Shared package uart_cmd_pkg shall contain the opcode constants, the CMD_TYPE encodings, the ERR_CODE encodings and the FSM state encoding.
REQ-032 The timer shall be one sub-module, uart_cmd_timer, instantiated only under UART_CMD_TIMEOUT_EN.

Verification
REQ-033 The bench shall cover these directed scenarios:
- Bytes AA,05,3C with CMD_READY=1: one CMD_VALID pulse with TYPE=0, ARG0=05, ARG1=3C, ARG2=00, and no error.
- Bytes CC,10,20,01 with CMD_READY=0 for 10 cycles: CMD_VALID held with stable ARG0..2=10,20,01; a byte 7F sent during the hold gives ERR code 3 and the command is unchanged.
- Byte 55: ERR code 0, no CMD_VALID; following bytes BB,09 give TYPE=1, ARG0=09.
- Bytes AA,05 then a byte with RX_PAR_ERR=1: ERR code 1, frame aborted; the next bytes DD,02 give TYPE=3, ARG0=02.
- With UART_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: byte AA then a 16-cycle gap gives ERR code 2 and IDLE; a byte arriving in exactly the expiry cycle gives no error.
- RST asserted after bytes CC,01: all outputs reset, no ERR_PULSE; the next frame BB,04 decodes correctly.
